// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator. A registered raster position
// (pos_x, pos_y) is advanced once per pixel clock-enable; sync, display
// enable and the line/frame strobes are registered alongside it so every
// output describes the same pixel in the same cycle.
//
// Optional feature (compile-time macro):
//   VGA_TIMING_FRAME_CNT_EN - when defined, frame_cnt counts frame starts
//                             since reset (modulo 2^FRAME_W). When undefined
//                             frame_cnt is tied to 0 and no counter exists.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset (wins over pix_ce)
//   pix_ce       in   pixel clock-enable; tie high when clk is the pixel clock
//   hsync        out  horizontal sync, asserted level = HS_POL
//   vsync        out  vertical sync, asserted level = VS_POL
//   de           out  display enable, high inside the active area
//   pos_x        out  current pixel column, 0 .. H_TOTAL-1
//   pos_y        out  current line, 0 .. V_TOTAL-1
//   line_start   out  one-clk strobe after the edge that loads pos_x = 0
//   frame_start  out  one-clk strobe after the edge that loads (0,0)
//   frame_cnt    out  frames since reset (see macro above)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [X_W-1:0]     pos_x,
    output logic [Y_W-1:0]     pos_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    logic [X_W-1:0] r_pos_x;
    logic [Y_W-1:0] r_pos_y;
    logic           r_hsync;
    logic           r_vsync;
    logic           r_de;
    logic           r_line_start;
    logic           r_frame_start;

    logic           w_x_wrap;
    logic           w_y_wrap;
    logic [X_W-1:0] w_next_x;
    logic [Y_W-1:0] w_next_y;
    logic           w_next_de;
    logic           w_next_hs_on;
    logic           w_next_vs_on;
    logic           w_line_hit;
    logic           w_frame_hit;

    // Decode from the position about to be loaded, so the registered flags
    // land on the same edge as the coordinates they describe.
    always_comb begin
        w_x_wrap     = (r_pos_x == X_W'(H_TOTAL - 1));
        w_y_wrap     = (r_pos_y == Y_W'(V_TOTAL - 1));
        w_next_x     = w_x_wrap ? '0 : r_pos_x + X_W'(1);
        w_next_y     = r_pos_y;
        if (w_x_wrap) begin
            w_next_y = w_y_wrap ? '0 : r_pos_y + Y_W'(1);
        end
        w_next_de    = (w_next_x < X_W'(H_ACTIVE)) && (w_next_y < Y_W'(V_ACTIVE));
        w_next_hs_on = (w_next_x >= X_W'(H_SYNC_START)) && (w_next_x < X_W'(H_SYNC_END));
        w_next_vs_on = (w_next_y >= Y_W'(V_SYNC_START)) && (w_next_y < Y_W'(V_SYNC_END));
        w_line_hit   = (w_next_x == '0);
        w_frame_hit  = w_line_hit && (w_next_y == '0);
    end

    // Reset parks the raster on the last pixel of the frame, so the first
    // enabled pixel after release is naturally (0,0) with both strobes.
    // NOTE: all state here uses non-blocking assignment so every register
    // samples the pre-edge values; blocking would chain next-state updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos_x       <= X_W'(H_TOTAL - 1);
            r_pos_y       <= Y_W'(V_TOTAL - 1);
            r_de          <= 1'b0;
            r_hsync       <= ~HS_ON;
            r_vsync       <= ~VS_ON;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // Strobes are one clk wide regardless of the pix_ce duty cycle.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (pix_ce) begin
                r_pos_x       <= w_next_x;
                r_pos_y       <= w_next_y;
                r_de          <= w_next_de;
                r_hsync       <= w_next_hs_on ? HS_ON : ~HS_ON;
                r_vsync       <= w_next_vs_on ? VS_ON : ~VS_ON;
                r_line_start  <= w_line_hit;
                r_frame_start <= w_frame_hit;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_W-1:0] r_frame_cnt;

    // Counts on the same edge that raises frame_start, so the first frame
    // after reset already reads 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (pix_ce && w_frame_hit) begin
            r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

    assign pos_x       = r_pos_x;
    assign pos_y       = r_pos_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
